uart_tx: RTL and testbench

Byte-wide UART transmitter that drives the SoC's `TXD` pin, which is currently tied to 0. The CPU side pushes bytes through a valid/ready port. The block serialises each byte as 8N1 (one start bit, 8 data bits LSB first, one stop bit) at a fixed baud rate. It runs on the divided core clock from the clock block, so the CPU store path or a debug writer can feed it directly.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_tx_fifo.sv | 107 ++++++++++
 rtl/uart_tx.sv | 156 +++++++++++++++
 tb/tb_uart_tx.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmitter.
//   - 2-bit state encodings IDLE/START/DATA/STOP and the typed FSM state enum
//   - frame constants DATA_BITS (8) and FRAME_BITS (10, 8N1)
//   - cnt_width(): baud counter width for a given bit period, never below 1
package uart_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    typedef enum logic [1:0] {
        StIdle  = IDLE,
        StStart = START,
        StData  = DATA,
        StStop  = STOP
    } tx_state_e;

    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned FRAME_BITS = 10;

    // Keeps the counter at least 1 bit wide so a bad bit period reaches the
    // elaboration check instead of failing on a zero-width vector first.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: transmit byte queue between the write port and the serialiser.
// Build option: UART_TX_FIFO_EN
//   defined   -> FIFO_DEPTH-entry circular FIFO, pointers one bit wider than
//                the address so full and empty stay distinct across wraps
//   undefined -> single holding register (FIFO_DEPTH only sanity-checked)
// Ports:
//   clk, reset  rising-edge clock, synchronous active-high reset (empties queue)
//   push, din   write request and byte; ignored while full
//   pop         remove the head entry; ignored while empty
//   dout        head entry (valid while !empty)
//   full, empty registered occupancy flags
module uart_tx_fifo #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    // Checked in both builds so a bad value is caught before the FIFO is enabled.
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end

    logic do_push;
    logic do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

`ifdef UART_TX_FIFO_EN

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [7:0]  mem_d [FIFO_DEPTH];

    always_comb begin
        wptr_d = wptr_q + (AW + 1)'(do_push);
        rptr_d = rptr_q + (AW + 1)'(do_pop);
        mem_d  = mem_q;
        if (do_push) begin
            mem_d[wptr_q[AW-1:0]] = din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign dout  = mem_q[rptr_q[AW-1:0]];

`else

    logic       valid_q, valid_d;
    logic [7:0] data_q, data_d;

    // push only lands when the register is empty, so it never meets a pop.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (do_pop) begin
            valid_d = 1'b0;
        end
        if (do_push) begin
            valid_d = 1'b1;
            data_d  = din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign empty = !valid_q;
    assign full  = valid_q;
    assign dout  = data_q;

`endif

endmodule

// File: rtl/uart_tx.sv
// uart_tx: byte-wide 8N1 UART transmitter with a valid/ready write port.
// Build option: UART_TX_FIFO_EN selects a FIFO_DEPTH-entry queue instead of a
// single holding register (see uart_tx_fifo).
// Parameters: CLK_FREQ_HZ, BAUD (CLKS_PER_BIT = CLK_FREQ_HZ / BAUD, must be >= 2),
//             FIFO_DEPTH.
// Ports:
//   clk       rising-edge clock
//   reset     synchronous active-high; aborts any frame and empties the queue
//   wr_data   byte to send
//   wr_valid  wr_data valid this cycle
//   wr_ready  queue not full (registered, independent of wr_valid)
//   busy      frame in progress or bytes queued
//   txd       serial line, idles high
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 27000000,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] wr_data,
    input  logic       wr_valid,
    output logic       wr_ready,
    output logic       busy,
    output logic       txd
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam int unsigned CntW         = cnt_width(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntMax   = CntW'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_tx: CLK_FREQ_HZ / BAUD must be at least 2");
    end

    tx_state_e       state_q, state_d;
    logic [CntW-1:0] baud_q, baud_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            txd_q, txd_d;

    logic       q_push;
    logic       q_pop;
    logic [7:0] q_dout;
    logic       q_full;
    logic       q_empty;
    logic       bit_done;

    assign q_push = wr_valid && !q_full;

    uart_tx_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (q_push),
        .pop  (q_pop),
        .din  (wr_data),
        .dout (q_dout),
        .full (q_full),
        .empty(q_empty)
    );

    assign bit_done = (baud_q == CntMax);

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        q_pop     = 1'b0;

        case (state_q)
            StIdle: begin
                if (!q_empty) begin
                    q_pop     = 1'b1;
                    shift_d   = q_dout;
                    baud_d    = '0;
                    bit_idx_d = 3'd0;
                    state_d   = StStart;
                end
            end
            StStart: begin
                if (bit_done) begin
                    baud_d    = '0;
                    bit_idx_d = 3'd0;
                    state_d   = StData;
                end else begin
                    baud_d = baud_q + CntW'(1);
                end
            end
            StData: begin
                if (bit_done) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + CntW'(1);
                end
            end
            StStop: begin
                if (bit_done) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when a byte is waiting.
                    if (!q_empty) begin
                        q_pop     = 1'b1;
                        shift_d   = q_dout;
                        bit_idx_d = 3'd0;
                        state_d   = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    baud_d = baud_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // txd is registered from the next state so the pin never glitches.
        case (state_d)
            StStart: txd_d = 1'b0;
            StData:  txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            baud_q    <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            txd_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
        end
    end

    assign txd      = txd_q;
    assign wr_ready = !q_full;
    assign busy     = (state_q != StIdle) || !q_empty;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx at CLKS_PER_BIT = 4.
// A frame-level model (pending-byte queue plus position inside a 40-cycle
// frame) predicts txd/busy/wr_ready every cycle; a line decoder recovers the
// bytes actually sent; directed tests pin both with literal expectations.
module tb_uart_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;
`ifdef UART_TX_FIFO_EN
    localparam int       CAP    = 4;
    localparam int       BURST  = 5;
    localparam bit [7:0] SECOND = 8'h81;
`else
    localparam int       CAP    = 1;
    localparam int       BURST  = 2;
    localparam bit [7:0] SECOND = 8'h82;
`endif

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data  = 8'h00;
    logic       wr_ready;
    logic       busy;
    logic       txd;

    uart_tx #(
        .CLK_FREQ_HZ(16),
        .BAUD       (4),
        .FIFO_DEPTH (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_data (wr_data),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .busy    (busy),
        .txd     (txd)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_q[$];
    logic [7:0] m_sent[$];
    int         acc_cyc[$];
    bit         m_valid  = 0;
    bit         m_active = 0;
    bit         m_acc    = 0;
    int         m_pos    = 0;
    logic [7:0] m_cur    = 8'h00;
    int         cyc      = 0;

    always @(posedge clk) begin
        cyc++;
        m_acc = 0;
        if (reset) begin
            m_q.delete();
            m_active = 0;
            m_pos    = 0;
            m_valid  = 1;
        end else begin
            // Acceptance uses occupancy before this edge's pop.
            m_acc = wr_valid && (m_q.size() < CAP);
            if (m_active) begin
                m_pos++;
                if (m_pos == FRAME) begin
                    if (m_q.size() > 0) begin
                        m_cur = m_q.pop_front();
                        m_pos = 0;
                    end else begin
                        m_active = 0;
                    end
                end
            end else if (m_q.size() > 0) begin
                m_cur    = m_q.pop_front();
                m_active = 1;
                m_pos    = 0;
            end
            if (m_acc) begin
                m_q.push_back(wr_data);
                m_sent.push_back(wr_data);
                acc_cyc.push_back(cyc);
            end
        end
    end

    function automatic logic exp_txd();
        int k;
        if (!m_active) return 1'b1;
        k = m_pos / CPB;
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return m_cur[k-1];
    endfunction

    always @(negedge clk) begin
        if (m_valid) begin
            check("cyc_txd", txd, exp_txd());
            check("cyc_busy", busy, m_active || (m_q.size() != 0));
            check("cyc_wr_ready", wr_ready, m_q.size() < CAP);
        end
    end

    // ---------------- line decoder ----------------
    bit         rx_busy = 0;
    int         rx_t    = 0;
    logic [7:0] rx_sh   = 8'h00;
    logic [7:0] rx_q[$];
    int         rx_start[$];

    always @(negedge clk) begin
        if (reset) begin
            rx_busy = 0;
        end else if (!rx_busy) begin
            if (txd === 1'b0) begin
                rx_busy = 1;
                rx_t    = 0;
                rx_start.push_back(cyc);
            end
        end else begin
            rx_t++;
            if (rx_t >= 6 && rx_t <= 34 && ((rx_t - 2) % 4) == 0) begin
                rx_sh[3'((rx_t - 6) / 4)] = txd;
            end
            if (rx_t == 38) begin
                rx_busy = 0;
                if (txd === 1'b1) rx_q.push_back(rx_sh);
            end
        end
    end

    // ---------------- stimulus helpers (run at posedge + 1) ----------------
    task automatic send(input logic [7:0] b);
        int n;
        wr_valid = 1'b1;
        wr_data  = b;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!m_acc && n < 200);
        wr_valid = 1'b0;
        check("send_accept", m_acc, 1'b1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((m_active || m_q.size() != 0 || rx_busy) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("idle_reached", n < 3000, 1'b1);
    endtask

    task automatic clear_logs();
        rx_q.delete();
        rx_start.delete();
        m_sent.delete();
        acc_cyc.delete();
    endtask

    initial begin
        logic [9:0] pat;
        int         n;
        int         cnt;

        // Reset
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_txd", txd, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_wr_ready", wr_ready, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_txd", txd, 1'b1);
        end
        @(posedge clk);
        #1;

        // Single byte 0x55: start, 1,0,1,0,1,0,1,0, stop
        clear_logs();
        pat = 10'b1010101010;
        send(8'h55);
        @(negedge clk);
        check("pre_start_txd", txd, 1'b1);
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            check("single_txd", txd, pat[k/CPB]);
        end
        check("single_busy_last", busy, 1'b1);
        @(negedge clk);
        check("single_busy_fall", busy, 1'b0);
        @(posedge clk);
        #1;
        wait_idle();
        check("single_rx_count", rx_q.size(), 1);
        if (rx_q.size() > 0) check("single_rx_byte", rx_q[0], 8'h55);

        // Back-to-back
        clear_logs();
        send(8'hA5);
        send(8'h3C);
        wait_idle();
        check("b2b_rx_count", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            check("b2b_rx0", rx_q[0], 8'hA5);
            check("b2b_rx1", rx_q[1], 8'h3C);
            check("b2b_gap", rx_start[1] - rx_start[0], FRAME);
        end

        // Full queue with continuous valid
        clear_logs();
        for (int b = 1; b <= 7; b++) send(8'(b));
        wait_idle();
        check("full_rx_count", rx_q.size(), 7);
        for (int i = 0; i < rx_q.size() && i < 7; i++) check("full_rx_byte", rx_q[i], i + 1);
        cnt = 0;
        for (int i = 0; i < acc_cyc.size(); i++) if (acc_cyc[i] - acc_cyc[0] <= 8) cnt++;
        check("full_burst_accepts", cnt, BURST);

        // Reset during data bit 3 of 0xFF with bytes queued
        clear_logs();
        send(8'hFF);
        send(8'h11);
        if (CAP >= 2) send(8'h22);
        n = 0;
        while (!(m_active && m_pos == 4 * CPB + 1) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("midrst_reached_bit3", n < 200, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midrst_txd", txd, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_wr_ready", wr_ready, 1'b1);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            check("midrst_quiet_txd", txd, 1'b1);
        end
        check("midrst_no_frames", rx_q.size(), 0);
        @(posedge clk);
        #1;

        // Hold-off: valid stays high, data changes every cycle
        clear_logs();
        for (int i = 0; i < 120; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(8'h80 + i);
            @(posedge clk);
            #1;
        end
        wr_valid = 1'b0;
        wait_idle();
        check("hold_rx_count", rx_q.size(), m_sent.size());
        for (int i = 0; i < rx_q.size() && i < m_sent.size(); i++)
            check("hold_rx_byte", rx_q[i], m_sent[i]);
        if (rx_q.size() >= 2) begin
            check("hold_first", rx_q[0], 8'h80);
            check("hold_second", rx_q[1], SECOND);
        end else begin
            check("hold_min_frames", rx_q.size(), 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
